cell_array_driver: RTL and testbench

CELL_ARRAY_DRIVER -- requirements
Module: cell_array_driver

---
 rtl/cell_array_pkg.sv | 28 ++
 rtl/cell_array_driver.sv | 144 ++++++++++++++
 tb/tb_cell_array_driver.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cell_array_pkg.sv
// Shared definitions for the cell array driver.
// Holds the sequencer state encoding and the helpers that derive the
// Linux IO word count (S1) and the RAM word count (S2) from parameters.
package cell_array_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_REQ,
    LOAD_WR,
    LOAD_HOLD,
    IN_WR,
    SETTLE,
    OUT_RD,
    OUT_CAP,
    DONE
  } state_t;

  // Number of PORT_WIDTH words in one DIMX-wide Linux IO row.
  function automatic int s1_words(input int dimx, input int port_width);
    return dimx / port_width;
  endfunction

  // Number of addressable genome words in the cell array RAM.
  function automatic int s2_words(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/cell_array_driver.sv
// Cell array driver: optionally streams a genome into the cell array RAM
// (S2 master), writes a test vector to the Linux IO inputs (S1 master),
// waits for the array to settle, then reads back the output vector.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start, load_en    run request (IDLE only) and genome reload select
//   test_in/test_out  DIMX-wide input vector / captured output vector
//   busy, done        sequence in progress / one-cycle completion pulse
//   in_valid/in_ready/in_data   genome word stream
//   m1_*              S1 Linux IO master (read/write, address, data)
//   m2_*              S2 RAM master (write, address, data)
module cell_array_driver
  import cell_array_pkg::*;
#(
  parameter int DIMX             = 64,
  parameter int PORT_WIDTH       = 32,
  parameter int S1_ADDRESS_WIDTH = 1,
  parameter int S2_ADDRESS_WIDTH = 9,
  parameter int SETTLE_CYCLES    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        load_en,
  input  logic [DIMX-1:0]             test_in,
  output logic [DIMX-1:0]             test_out,
  output logic                        busy,
  output logic                        done,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PORT_WIDTH-1:0]       in_data,
  output logic                        m1_read,
  output logic                        m1_write,
  output logic [S1_ADDRESS_WIDTH-1:0] m1_address,
  output logic [PORT_WIDTH-1:0]       m1_writedata,
  input  logic [PORT_WIDTH-1:0]       m1_readdata,
  output logic                        m2_write,
  output logic [S2_ADDRESS_WIDTH-1:0] m2_address,
  output logic [PORT_WIDTH-1:0]       m2_writedata
);

  localparam int S1_WORDS = s1_words(DIMX, PORT_WIDTH);
  localparam int S2_WORDS = s2_words(S2_ADDRESS_WIDTH);
  localparam int KW       = $clog2(S1_WORDS) + 1;
  localparam int IW       = $clog2(S2_WORDS) + 1;
  localparam int SW       = $clog2(SETTLE_CYCLES) + 1;

  localparam logic [KW-1:0] K_LAST      = KW'(S1_WORDS - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(S2_WORDS - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  state_t                state;
  state_t                next_state;
  logic [KW-1:0]         k;
  logic [IW-1:0]         idx;
  logic [SW-1:0]         settle_cnt;
  logic [PORT_WIDTH-1:0] word_reg;
  logic [DIMX-1:0]       test_in_reg;
  logic [DIMX-1:0]       test_out_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start) next_state = load_en ? LOAD_REQ : IN_WR;
      LOAD_REQ:  if (in_valid) next_state = LOAD_WR;
      LOAD_WR:   next_state = LOAD_HOLD;
      LOAD_HOLD: next_state = (idx == IDX_LAST) ? IN_WR : LOAD_REQ;
      IN_WR:     if (k == K_LAST) next_state = SETTLE;
      SETTLE:    if (settle_cnt == SETTLE_LAST) next_state = OUT_RD;
      OUT_RD:    next_state = OUT_CAP;
      OUT_CAP:   next_state = (k == K_LAST) ? DONE : OUT_RD;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Datapath registers. The genome index saturates at the last word rather
  // than wrapping, so the RAM address stays stable through the final hold
  // cycle and the IN_WR phase that follows it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k            <= '0;
      idx          <= '0;
      settle_cnt   <= '0;
      word_reg     <= '0;
      test_in_reg  <= '0;
      test_out_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            test_in_reg <= test_in;
            idx         <= '0;
            k           <= '0;
            settle_cnt  <= '0;
          end
        end
        LOAD_REQ: begin
          if (in_valid) word_reg <= in_data;
        end
        LOAD_HOLD: begin
          if (idx != IDX_LAST) idx <= idx + IW'(1);
        end
        IN_WR: begin
          if (k == K_LAST) begin
            k          <= '0;
            settle_cnt <= '0;
          end else begin
            k <= k + KW'(1);
          end
        end
        SETTLE: begin
          if (settle_cnt != SETTLE_LAST) settle_cnt <= settle_cnt + SW'(1);
        end
        OUT_CAP: begin
          test_out_reg[k*PORT_WIDTH +: PORT_WIDTH] <= m1_readdata;
          if (k != K_LAST) k <= k + KW'(1);
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from the state register, so they are mutually
  // exclusive by construction and drop together with an asynchronous reset.
  assign in_ready     = (state == LOAD_REQ);
  assign m2_write     = (state == LOAD_WR);
  assign m1_write     = (state == IN_WR);
  assign m1_read      = (state == OUT_RD);
  assign done         = (state == DONE);
  assign busy         = (state != IDLE) && (state != DONE);
  assign m2_address   = S2_ADDRESS_WIDTH'(idx);
  assign m2_writedata = word_reg;
  assign m1_address   = S1_ADDRESS_WIDTH'(k);
  assign m1_writedata = (state == IN_WR) ? test_in_reg[k*PORT_WIDTH +: PORT_WIDTH] : '0;
  assign test_out     = test_out_reg;

endmodule

// File: tb/tb_cell_array_driver.sv
// Directed testbench for cell_array_driver with a four-word genome RAM.
module tb_cell_array_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        load_en;
  logic [63:0] test_in;
  logic [63:0] test_out;
  logic        busy;
  logic        done;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        m1_read;
  logic        m1_write;
  logic [0:0]  m1_address;
  logic [31:0] m1_writedata;
  logic [31:0] m1_readdata = 32'h0;
  logic        m2_write;
  logic [1:0]  m2_address;
  logic [31:0] m2_writedata;

  int total = 0;
  int bad   = 0;

  cell_array_driver #(
    .DIMX(64), .PORT_WIDTH(32), .S1_ADDRESS_WIDTH(1),
    .S2_ADDRESS_WIDTH(2), .SETTLE_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .load_en(load_en),
    .test_in(test_in), .test_out(test_out), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
    .m2_write(m2_write), .m2_address(m2_address), .m2_writedata(m2_writedata)
  );

  always #5 clk = ~clk;

  // Linux IO slave: one-cycle read latency, fixed data per address.
  always @(posedge clk)
    if (m1_read) m1_readdata <= (m1_address == 1'b0) ? 32'hCAFEBABE : 32'hDEADBEEF;

  logic [31:0] words [4];

  // Observations gathered by run_sequence, judged by the test tasks.
  int          done_cyc, done_cnt, m2_wr_cnt, m1_wr_cnt, hold_err, conflict_cnt;
  int          last_m1_wr_cyc, first_m1_rd_cyc, stall_err, busy_err, busy_after_done;
  logic [1:0]  m2_addr_log [8];
  logic [31:0] m2_data_log [8];
  logic [0:0]  m1_addr_log [4];
  logic [31:0] m1_data_log [4];
  logic [5:0]  rst_obs_flags;
  logic [63:0] rst_obs_out;
  logic [31:0] rst_obs_data;

  task automatic run_sequence(input logic le, input logic [63:0] tin, input int stall_word,
                              input int stall_len, input int reset_at, input int restart_at);
    int cyc, widx, stall_cnt, after_done;
    logic xfer, prev_m2w, reset_seen;
    logic [1:0] prev_a;
    logic [31:0] prev_d;
    done_cyc = -1; done_cnt = 0; m2_wr_cnt = 0; m1_wr_cnt = 0; hold_err = 0;
    conflict_cnt = 0; last_m1_wr_cyc = -1; first_m1_rd_cyc = -1; stall_err = 0;
    busy_err = 0; busy_after_done = 0; rst_obs_flags = '1; rst_obs_out = '1; rst_obs_data = '1;
    cyc = 0; widx = 0; stall_cnt = 0; after_done = -1; xfer = 0; prev_m2w = 0;
    prev_a = '0; prev_d = '0; reset_seen = 0;
    start = 1'b1; load_en = le; test_in = tin; in_valid = 1'b0; in_data = words[0];
    while (cyc < 300) begin
      @(posedge clk);
      cyc++;
      if (xfer && widx < 3) widx++;
      else if (xfer) widx = 4;
      #1;
      if (reset_seen && cyc == reset_at + 2) rst = 1'b1;
      start   = (cyc == restart_at);
      load_en = ~le;
      test_in = ~tin;
      if (!reset_seen && done_cnt == 0 && !done && busy !== 1'b1) busy_err++;
      if (prev_m2w && (m2_write !== 1'b0 || m2_address !== prev_a || m2_writedata !== prev_d))
        hold_err++;
      if (m2_write) begin
        if (m2_wr_cnt < 8) begin
          m2_addr_log[m2_wr_cnt] = m2_address;
          m2_data_log[m2_wr_cnt] = m2_writedata;
        end
        m2_wr_cnt++;
      end
      prev_m2w = m2_write; prev_a = m2_address; prev_d = m2_writedata;
      if ((m1_read && m1_write) || ((m1_read || m1_write) && m2_write)) conflict_cnt++;
      if (m1_write) begin
        if (m1_wr_cnt < 4) begin
          m1_addr_log[m1_wr_cnt] = m1_address;
          m1_data_log[m1_wr_cnt] = m1_writedata;
        end
        m1_wr_cnt++;
        last_m1_wr_cyc = cyc;
      end
      if (m1_read && first_m1_rd_cyc < 0) first_m1_rd_cyc = cyc;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (busy) busy_err++;
        if (after_done < 0) after_done = 0;
      end else if (after_done >= 0) begin
        after_done++;
        if (busy) busy_after_done++;
      end
      if (after_done >= 3) break;
      if (reset_seen && cyc > reset_at + 30) break;
      in_valid = 1'b1;
      if (widx == stall_word && stall_cnt < stall_len) begin
        if (stall_cnt > 0 && !in_ready) stall_err++;
        in_valid = 1'b0;
        if (in_ready) stall_cnt++;
      end
      in_data = words[(widx < 4) ? widx : 3];
      xfer = in_valid && in_ready;
      if (cyc == reset_at) begin
        #2 rst = 1'b0;
        #1;
        rst_obs_flags = {m1_read, m1_write, m2_write, in_ready, busy, done};
        rst_obs_out   = test_out;
        rst_obs_data  = m2_writedata | {31'b0, m2_address[0] | m2_address[1] | m1_address[0]}
                        | m1_writedata;
        reset_seen = 1'b1;
        xfer = 1'b0;
      end
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; load_en = 1'b0; test_in = '0; in_valid = 1'b0; in_data = '0;
    #1;
    total++;
    if ({m1_read, m1_write, m2_write, in_ready, busy, done} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {m1_read, m1_write, m2_write, in_ready, busy, done});
    end
    total++;
    if ({test_out, m2_writedata, m1_writedata, m2_address, m1_address} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_data: test_out=%h m2d=%h m1d=%h m2a=%h m1a=%h expected all zero",
               test_out, m2_writedata, m1_writedata, m2_address, m1_address);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_genome_load();
    run_sequence(1'b1, 64'h0123_4567_89AB_CDEF, -1, 0, -1, -1);
    total++;
    if (m2_wr_cnt !== 4) begin bad++; $display("[TB] FAIL load_wr_count: got %0d expected 4", m2_wr_cnt); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (m2_addr_log[i] !== 2'(i) || m2_data_log[i] !== words[i]) begin
        bad++;
        $display("[TB] FAIL load_word%0d: got addr %0d data %h expected addr %0d data %h",
                 i, m2_addr_log[i], m2_data_log[i], i, words[i]);
      end
    end
    total++;
    if (hold_err !== 0) begin bad++; $display("[TB] FAIL load_hold: got %0d violations expected 0", hold_err); end
    total++;
    if (conflict_cnt !== 0) begin bad++; $display("[TB] FAIL load_strobes: got %0d conflicts expected 0", conflict_cnt); end
    total++;
    if (done_cyc !== 35 || done_cnt !== 1) begin
      bad++; $display("[TB] FAIL load_done: got cycle %0d count %0d expected cycle 35 count 1", done_cyc, done_cnt);
    end
    total++;
    if (first_m1_rd_cyc - last_m1_wr_cyc !== 17) begin
      bad++; $display("[TB] FAIL load_settle: got gap %0d expected 17", first_m1_rd_cyc - last_m1_wr_cyc);
    end
    total++;
    if (busy_err !== 0 || busy_after_done !== 0) begin
      bad++; $display("[TB] FAIL load_busy: got %0d/%0d errors expected 0/0", busy_err, busy_after_done);
    end
    total++;
    if (test_out !== 64'hDEADBEEF_CAFEBABE) begin
      bad++; $display("[TB] FAIL load_test_out: got %h expected deadbeefcafebabe", test_out);
    end
  endtask

  task automatic test_linux_io();
    logic [63:0] vec [2];
    logic [31:0] exp_lo [2];
    logic [31:0] exp_hi [2];
    vec[0] = 64'h0123_4567_89AB_CDEF; exp_lo[0] = 32'h89ABCDEF; exp_hi[0] = 32'h01234567;
    vec[1] = 64'hFEDC_BA98_7654_3210; exp_lo[1] = 32'h76543210; exp_hi[1] = 32'hFEDCBA98;
    for (int v = 0; v < 2; v++) begin
      run_sequence(1'b0, vec[v], -1, 0, -1, -1);
      total++;
      if (m2_wr_cnt !== 0 || m1_wr_cnt !== 2) begin
        bad++; $display("[TB] FAIL io_counts%0d: got m2=%0d m1=%0d expected m2=0 m1=2", v, m2_wr_cnt, m1_wr_cnt);
      end
      total++;
      if (m1_addr_log[0] !== 1'b0 || m1_data_log[0] !== exp_lo[v] ||
          m1_addr_log[1] !== 1'b1 || m1_data_log[1] !== exp_hi[v]) begin
        bad++;
        $display("[TB] FAIL io_writes%0d: got %0d:%h %0d:%h expected 0:%h 1:%h", v, m1_addr_log[0],
                 m1_data_log[0], m1_addr_log[1], m1_data_log[1], exp_lo[v], exp_hi[v]);
      end
      total++;
      if (done_cyc !== 23 || done_cnt !== 1) begin
        bad++; $display("[TB] FAIL io_done%0d: got cycle %0d count %0d expected cycle 23 count 1", v, done_cyc, done_cnt);
      end
      total++;
      if (test_out !== 64'hDEADBEEF_CAFEBABE || first_m1_rd_cyc - last_m1_wr_cyc !== 17) begin
        bad++; $display("[TB] FAIL io_readback%0d: got %h gap %0d expected deadbeefcafebabe gap 17",
                        v, test_out, first_m1_rd_cyc - last_m1_wr_cyc);
      end
    end
  endtask

  task automatic test_stream_stall();
    run_sequence(1'b1, 64'h1111_2222_3333_4444, 2, 5, -1, -1);
    total++;
    if (stall_err !== 0) begin bad++; $display("[TB] FAIL stall_ready: got %0d drops expected 0", stall_err); end
    total++;
    if (done_cyc !== 40 || done_cnt !== 1) begin
      bad++; $display("[TB] FAIL stall_done: got cycle %0d count %0d expected cycle 40 count 1", done_cyc, done_cnt);
    end
    total++;
    if (m2_wr_cnt !== 4 || m2_data_log[2] !== words[2] || m2_addr_log[3] !== 2'd3 || hold_err !== 0) begin
      bad++; $display("[TB] FAIL stall_writes: got count %0d word2 %h addr3 %0d holds %0d expected 4 %h 3 0",
                      m2_wr_cnt, m2_data_log[2], m2_addr_log[3], hold_err, words[2]);
    end
  endtask

  task automatic test_reset_mid();
    run_sequence(1'b1, 64'h5555_6666_7777_8888, -1, 0, 20, -1);
    total++;
    if (rst_obs_flags !== 6'b0 || rst_obs_out !== 64'h0 || rst_obs_data !== 32'h0) begin
      bad++; $display("[TB] FAIL midreset_outputs: got flags %b out %h data %h expected all zero",
                      rst_obs_flags, rst_obs_out, rst_obs_data);
    end
    total++;
    if (done_cnt !== 0) begin bad++; $display("[TB] FAIL midreset_nodone: got %0d done pulses expected 0", done_cnt); end
    run_sequence(1'b1, 64'h5555_6666_7777_8888, -1, 0, -1, -1);
    total++;
    if (done_cyc !== 35 || m2_wr_cnt !== 4 || m2_addr_log[0] !== 2'd0 || m2_data_log[0] !== words[0]) begin
      bad++; $display("[TB] FAIL midreset_rerun: got cycle %0d writes %0d addr0 %0d data0 %h expected 35 4 0 %h",
                      done_cyc, m2_wr_cnt, m2_addr_log[0], m2_data_log[0], words[0]);
    end
  endtask

  task automatic test_start_while_busy();
    int restarts [2];
    restarts[0] = 5; restarts[1] = 22;
    for (int r = 0; r < 2; r++) begin
      run_sequence(1'b0, 64'h0123_4567_89AB_CDEF, -1, 0, -1, restarts[r]);
      total++;
      if (done_cnt !== 1 || done_cyc !== 23 || busy_after_done !== 0 || m2_wr_cnt !== 0) begin
        bad++; $display("[TB] FAIL busy_start%0d: got done %0d at %0d busy_after %0d m2 %0d expected 1 at 23 0 0",
                        r, done_cnt, done_cyc, busy_after_done, m2_wr_cnt);
      end
    end
  endtask

  initial begin
    words[0] = 32'hA000_00A0;
    words[1] = 32'hA111_11A1;
    words[2] = 32'hA222_22A2;
    words[3] = 32'hA333_33A3;
    test_reset();
    test_genome_load();
    test_linux_io();
    test_stream_stall();
    test_reset_mid();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
